// File: rtl/mul_pkg.sv
// Shared constants and encodings for the ARMv4 32x32 multiplier.
package mul_pkg;

  localparam int MUL_WIDTH = 32;
  localparam logic [MUL_WIDTH-1:0] MUL_IDLE = '1;

  typedef enum logic {
    MUL_SEL_LO = 1'b0,
    MUL_SEL_HI = 1'b1
  } mul_sel_e;

  typedef enum logic {
    MUL_UNSIGNED = 1'b0,
    MUL_SIGNED   = 1'b1
  } mul_sign_e;

endpackage

// File: rtl/mul_core.sv
// Radix-4 Booth multiplier: full 2W-bit product of two W-bit operands, signed or unsigned.
module mul_core #(
  parameter int W = 32
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  logic           i_signed,
  output logic [2*W-1:0] o_prod
);

  localparam int EW = W + 2;   // two guard bits make unsigned operands look signed
  localparam int ND = EW / 2;
  localparam int PW = 2 * W;

  logic [EW-1:0]        w_a_ext, w_b_ext;
  logic [PW-1:0]        w_a_pw;
  logic [EW:0]          w_y;
  logic [ND-1:0][PW-1:0] w_pp;

  assign w_a_ext = {{2{i_signed & i_a[W-1]}}, i_a};
  assign w_b_ext = {{2{i_signed & i_b[W-1]}}, i_b};
  assign w_a_pw  = {{(PW-EW){w_a_ext[EW-1]}}, w_a_ext};
  assign w_y     = {w_b_ext, 1'b0};

  for (genvar gi = 0; gi < ND; gi++) begin : g_pp
    logic [2:0]    w_trip;
    logic [PW-1:0] w_mag;
    logic          w_neg;

    assign w_trip = w_y[2*gi+2 -: 3];
    assign w_neg  = w_trip[2] & ~(w_trip[1] & w_trip[0]);

    always_comb begin
      w_mag = '0;
      case (w_trip)
        3'b001, 3'b010, 3'b101, 3'b110: w_mag = w_a_pw;
        3'b011, 3'b100:                 w_mag = w_a_pw << 1;
        default:                        w_mag = '0;
      endcase
    end

    assign w_pp[gi] = (w_neg ? (~w_mag + 1'b1) : w_mag) << (2 * gi);
  end

  // Carry-save array: rows fold into a sum/carry pair, resolved by one final add.
  logic [PW-1:0] w_s, w_c, w_ns;
  always_comb begin
    w_s  = '0;
    w_c  = '0;
    w_ns = '0;
    for (int k = 0; k < ND; k++) begin
      w_ns = w_s ^ w_c ^ w_pp[k];
      w_c  = ((w_s & w_c) | (w_s & w_pp[k]) | (w_c & w_pp[k])) << 1;
      w_s  = w_ns;
    end
  end

  assign o_prod = w_s + w_c;

endmodule

// File: rtl/mul.sv
// ARMv4 multiplier top: idle/reset forcing and half select around mul_core.
// Define MUL_OUT_REG_EN to register B_Out (1-cycle latency); default is combinational.
module mul
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] B_In,
  input  logic [WIDTH-1:0] C,
  input  logic             MUL_HiLo,
  input  logic             LD_MUL,
  input  logic             U,
  output logic [WIDTH-1:0] B_Out
);

  localparam logic [WIDTH-1:0] W_IDLE = '1;

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_half, w_res;
  logic               w_signed;

  assign w_signed = (U == MUL_SIGNED);

  mul_core #(.W(WIDTH)) u_core (
    .i_a      (B_In),
    .i_b      (C),
    .i_signed (w_signed),
    .o_prod   (w_prod)
  );

  assign w_half = (MUL_HiLo == MUL_SEL_HI) ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
  assign w_res  = LD_MUL ? w_half : W_IDLE;

`ifdef MUL_OUT_REG_EN
  logic [WIDTH-1:0] r_out;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_out <= W_IDLE;
    else     r_out <= w_res;
  end
  assign B_Out = r_out;
`else
  logic w_unused_clk;
  assign w_unused_clk = clk;
  assign B_Out = rst ? W_IDLE : w_res;
`endif

endmodule

// File: tb/tb_mul.sv
// Scoreboard bench for mul; works with or without MUL_OUT_REG_EN (checks 1 ns after each edge).
module tb_mul;
  import mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] B_In, C;
  logic        MUL_HiLo, LD_MUL, U;
  logic [31:0] B_Out;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  mul dut (
    .clk      (clk),
    .rst      (rst),
    .B_In     (B_In),
    .C        (C),
    .MUL_HiLo (MUL_HiLo),
    .LD_MUL   (LD_MUL),
    .U        (U),
    .B_Out    (B_Out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [31:0] b, input logic [31:0] c,
                                        input logic hilo, input logic u, input logic ld);
    logic [63:0] bx, cx, p;
    bx = u ? {{32{b[31]}}, b} : {32'h0, b};
    cx = u ? {{32{c[31]}}, c} : {32'h0, c};
    p  = bx * cx;
    if (!ld) return MUL_IDLE;
    return hilo ? p[63:32] : p[31:0];
  endfunction

  // Drive one operation, push its expectation, compare after the next edge.
  task automatic apply(input string tag, input int b, input int c, input logic hilo,
                       input logic u, input logic ld, input logic [31:0] exp);
    sb_t e;
    B_In = b; C = c; MUL_HiLo = hilo; U = u; LD_MUL = ld;
    sb_q.push_back('{tag, exp});
    @(posedge clk); #1;
    if (sb_q.size() == 0) begin
      n_chk++; n_err++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, B_Out, e.exp);
    end
  endtask

  initial begin
    int ib[4];
    int ic[4];
    logic [31:0] rb, rc;
    logic rh, ru, rl;
    ib = '{5, -4000000, 20, -1234};
    ic = '{5, 4000000, -5000, -5678};

    rst = 1'b1; B_In = 5; C = 5; MUL_HiLo = 1'b0; LD_MUL = 1'b1; U = 1'b0;
    #1;
    chk("reset_idle", B_Out, 32'hFFFFFFFF);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_release", B_Out, 32'd25);

    for (int i = 0; i < 4; i++)
      for (int m = 0; m < 4; m++)
        apply("idle_sweep", ib[i], ic[i], m[1], m[0], 1'b0, 32'hFFFFFFFF);

    apply("ulo_5x5",      5,          5,          1'b0, 1'b0, 1'b1, 32'd25);
    apply("ulo_2kx2k",    2000,       2000,       1'b0, 1'b0, 1'b1, 32'd4000000);
    apply("ulo_4mx4m",    4000000,    4000000,    1'b0, 1'b0, 1'b1, 32'h4A510000);
    apply("ulo_2gx1g",    2000000000, 1000000000, 1'b0, 1'b0, 1'b1, 32'h4EC80000);
    apply("uhi_5x5",      5,          5,          1'b1, 1'b0, 1'b1, 32'h0);
    apply("uhi_2kx2k",    2000,       2000,       1'b1, 1'b0, 1'b1, 32'h0);
    apply("uhi_4mx4m",    4000000,    4000000,    1'b1, 1'b0, 1'b1, 32'h00000E8D);
    apply("uhi_2gx1g",    2000000000, 1000000000, 1'b1, 1'b0, 1'b1, 32'h1BC16D67);
    apply("slo_m3x3",     -3,         3,          1'b0, 1'b1, 1'b1, -9);
    apply("slo_4xm4",     4,          -4,         1'b0, 1'b1, 1'b1, -16);
    apply("slo_m5xm5",    -5,         -5,         1'b0, 1'b1, 1'b1, 32'd25);
    apply("slo_m4mx4m",   -4000000,   4000000,    1'b0, 1'b1, 1'b1, 32'hB5AF0000);
    apply("slo_1gxm20",   1000000000, -20,        1'b0, 1'b1, 1'b1, 32'h57E83800);
    apply("slo_m2gxm1g",  -2000000000,-1000000000,1'b0, 1'b1, 1'b1, 32'h4EC80000);
    apply("shi_m3x3",     -3,         3,          1'b1, 1'b1, 1'b1, 32'hFFFFFFFF);
    apply("shi_4xm4",     4,          -4,         1'b1, 1'b1, 1'b1, 32'hFFFFFFFF);
    apply("shi_m5xm5",    -5,         -5,         1'b1, 1'b1, 1'b1, 32'h0);
    apply("shi_m4mx4m",   -4000000,   4000000,    1'b1, 1'b1, 1'b1, 32'hFFFFF172);
    apply("shi_1gxm20",   1000000000, -20,        1'b1, 1'b1, 1'b1, 32'hFFFFFFFB);
    apply("shi_m2gxm1g",  -2000000000,-1000000000,1'b1, 1'b1, 1'b1, 32'h1BC16D67);

    // Boundaries: most-negative squared, zero operands, all-ones unsigned.
    apply("shi_minneg2",  32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1, 32'h40000000);
    apply("slo_minneg2",  32'h80000000, 32'h80000000, 1'b0, 1'b1, 1'b1, 32'h0);
    apply("uhi_minneg2",  32'h80000000, 32'h80000000, 1'b1, 1'b0, 1'b1, 32'h40000000);
    apply("shi_zero",     0,            -7,           1'b1, 1'b1, 1'b1, 32'h0);
    apply("slo_zero",     -7,           0,            1'b0, 1'b1, 1'b1, 32'h0);
    apply("uhi_ones2",    -1,           -1,           1'b1, 1'b0, 1'b1, 32'hFFFFFFFE);
    apply("ulo_ones2",    -1,           -1,           1'b0, 1'b0, 1'b1, 32'h00000001);
    apply("shi_ones2",    -1,           -1,           1'b1, 1'b1, 1'b1, 32'h0);

    for (int i = 0; i < 200; i++) begin
      rb = $urandom; rc = $urandom;
      if (i % 8 == 0) rb = {$urandom_range(1, 0) == 1 ? 1'b1 : 1'b0, 31'($urandom_range(255, 0))};
      rh = 1'($urandom_range(1, 0));
      ru = 1'($urandom_range(1, 0));
      rl = ($urandom_range(7, 0) != 0);
      apply("random", rb, rc, rh, ru, rl, model(rb, rc, rh, ru, rl));
    end

    // Reset during a loaded multiply forces idle at once, product returns after release.
    B_In = 5; C = 5; MUL_HiLo = 1'b0; U = 1'b0; LD_MUL = 1'b1;
    @(negedge clk); rst = 1'b1; #1;
    chk("reset_async", B_Out, 32'hFFFFFFFF);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_release2", B_Out, 32'd25);

    if (sb_q.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
